// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start/data/parity/stop FSM with optional
// oversampling (mid-bit sampling), registered frame outputs and error flags.
module uart_rx #(
  parameter int unsigned ODD_nEVEN       = 1,
  parameter int unsigned SAMPLES_PER_BIT = 1
) (
  input  logic       UART_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned N  = SAMPLES_PER_BIT;
  localparam int unsigned M  = (N - 1) / 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(N - 1);
  localparam logic [CW-1:0] TICK_MID  = CW'(M);
  localparam logic          M_ZERO    = (M == 0) ? 1'b1 : 1'b0;
  localparam logic          ODD_BIT   = 1'(ODD_nEVEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic parity_mismatch(input logic [7:0] data, input logic rx_par,
                                           input logic odd);
    return rx_par ^ (^data) ^ odd;
  endfunction

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_sync_q, prev_q;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic        edge_s;

  // A start edge needs the line seen high in the previous cycle.
  assign edge_s = ~rx_sync_q & prev_q;

  // Next-state and output-register logic for the receive FSM.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (edge_s) begin
          busy_d = 1'b1;
          bit_d  = 3'd0;
          if (M_ZERO) begin
            state_d = S_DATA;
            tick_d  = CW'(0);
          end else begin
            state_d = S_START;
            tick_d  = CW'(1);
          end
        end else begin
          tick_d = CW'(0);
        end
      end
      S_START: begin
        if (tick_q == TICK_MID) begin
          tick_d = CW'(0);
          if (!rx_sync_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = CW'(0);
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = CW'(0);
          par_d   = rx_sync_q;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      S_STOP: begin
        // Outputs are registered here so they are visible in the DONE cycle.
        if (tick_q == TICK_LAST) begin
          tick_d  = CW'(0);
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          data_d  = shift_q;
          perr_d  = parity_mismatch(shift_q, par_q, ODD_BIT);
          ferr_d  = ~rx_sync_q;
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        tick_d  = CW'(0);
      end
    endcase
  end

  // Synchroniser, edge history and all FSM/output registers.
  always_ff @(posedge UART_clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= S_IDLE;
      tick_q    <= CW'(0);
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      prev_q    <= rx_sync_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out     = data_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one instance at 1 clock/bit, one at 16 clocks/bit.
module tb_uart_rx;
  timeunit 1ns;
  timeprecision 1ns;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    time        t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx16 = 1'b1;
  logic [7:0] data1, data16;
  logic       done1, done16, perr1, perr16, ferr1, ferr16, busy1, busy16;

  int   checks = 0;
  int   errors = 0;
  exp_t sb1[$];
  exp_t sb16[$];
  exp_t e1, e16;

  always #5 clk = ~clk;

  uart_rx #(.ODD_nEVEN(1), .SAMPLES_PER_BIT(1)) dut1 (
    .UART_clk(clk), .rst(rst), .rx(rx1), .data_out(data1), .rx_done_tick(done1),
    .parity_err(perr1), .frame_err(ferr1), .rx_busy(busy1)
  );

  uart_rx #(.ODD_nEVEN(1), .SAMPLES_PER_BIT(16)) dut16 (
    .UART_clk(clk), .rst(rst), .rx(rx16), .data_out(data16), .rx_done_tick(done16),
    .parity_err(perr16), .frame_err(ferr16), .rx_busy(busy16)
  );

  // Scoreboard: pop an expected frame each time a DUT pulses rx_done_tick.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL n1_unexpected_done at %0t got pulse expected none", $time);
      end else begin
        e1 = sb1.pop_front();
        checks += 4;
        if (data1 !== e1.d) begin errors++; $display("FAIL n1_data got %h expected %h", data1, e1.d); end
        if (perr1 !== e1.pe) begin errors++; $display("FAIL n1_parity_err got %b expected %b", perr1, e1.pe); end
        if (ferr1 !== e1.fe) begin errors++; $display("FAIL n1_frame_err got %b expected %b", ferr1, e1.fe); end
        if ($time != e1.t) begin errors++; $display("FAIL n1_latency got %0t expected %0t", $time, e1.t); end
      end
      checks++;
      if (busy1 !== 1'b0) begin errors++; $display("FAIL n1_busy_in_done got %b expected 0", busy1); end
    end
    if (done16 === 1'b1) begin
      checks++;
      if (sb16.size() == 0) begin
        errors++;
        $display("FAIL n16_unexpected_done at %0t got pulse expected none", $time);
      end else begin
        e16 = sb16.pop_front();
        checks += 4;
        if (data16 !== e16.d) begin errors++; $display("FAIL n16_data got %h expected %h", data16, e16.d); end
        if (perr16 !== e16.pe) begin errors++; $display("FAIL n16_parity_err got %b expected %b", perr16, e16.pe); end
        if (ferr16 !== e16.fe) begin errors++; $display("FAIL n16_frame_err got %b expected %b", ferr16, e16.fe); end
        if ($time != e16.t) begin errors++; $display("FAIL n16_latency got %0t expected %0t", $time, e16.t); end
      end
    end
  end

  // Hold a line level for n clocks, starting and ending on a falling clock edge.
  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rx16 = v;
    else     rx1  = v;
    repeat (n) @(negedge clk);
  endtask

  // Send one frame and push its expected result (odd parity, optional faults).
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par_flip,
                            input logic stop);
    int   n;
    int   m;
    exp_t e;
    logic par;
    n     = sel ? 16 : 1;
    m     = (n - 1) / 2;
    par   = (^d) ^ 1'b1 ^ par_flip;
    e.d   = d;
    e.pe  = par_flip;
    e.fe  = ~stop;
    e.t   = $time + time'((3 + m + 10 * n) * 10);
    if (sel) sb16.push_back(e);
    else     sb1.push_back(e);
    drive_bit(sel, 1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], n);
    drive_bit(sel, par, n);
    drive_bit(sel, stop, n);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks += 5;
    if (data1 !== 8'h00 || data16 !== 8'h00) begin errors++; $display("FAIL reset_data got %h/%h expected 00", data1, data16); end
    if (done1 !== 1'b0 || done16 !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b expected 0", done1, done16); end
    if (perr1 !== 1'b0 || perr16 !== 1'b0) begin errors++; $display("FAIL reset_perr got %b/%b expected 0", perr1, perr16); end
    if (ferr1 !== 1'b0 || ferr16 !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b/%b expected 0", ferr1, ferr16); end
    if (busy1 !== 1'b0 || busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b expected 0", busy1, busy16); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback;
    logic [7:0] vals [4];
    vals = '{8'h55, 8'h00, 8'hFF, 8'hA7};
    for (int i = 0; i < 4; i++) begin
      send_frame(1'b0, vals[i], 1'b0, 1'b1);
      drive_bit(1'b0, 1'b1, 1);
    end
    drive_bit(1'b0, 1'b1, 20);
    checks += 2;
    if (sb1.size() != 0) begin errors++; $display("FAIL loopback_missing got %0d pending expected 0", sb1.size()); end
    if (data1 !== 8'hA7) begin errors++; $display("FAIL loopback_hold got %h expected a7", data1); end
  endtask

  task automatic test_parity_err;
    send_frame(1'b0, 8'h3C, 1'b1, 1'b1);
    drive_bit(1'b0, 1'b1, 15);
    checks += 2;
    if (sb1.size() != 0) begin errors++; $display("FAIL parity_missing got %0d pending expected 0", sb1.size()); end
    if (perr1 !== 1'b1) begin errors++; $display("FAIL parity_hold got %b expected 1", perr1); end
  endtask

  task automatic test_frame_err;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1, 4);
    send_frame(1'b0, 8'h12, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 15);
    checks += 2;
    if (sb1.size() != 0) begin errors++; $display("FAIL frame_missing got %0d pending expected 0", sb1.size()); end
    if (ferr1 !== 1'b0 || data1 !== 8'h12) begin errors++; $display("FAIL frame_recover got ferr=%b data=%h expected ferr=0 data=12", ferr1, data1); end
  endtask

  task automatic test_oversample;
    drive_bit(1'b1, 1'b0, 3);
    drive_bit(1'b1, 1'b1, 0);
    checks++;
    if (busy16 !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b expected 1", busy16); end
    drive_bit(1'b1, 1'b1, 20);
    checks++;
    if (busy16 !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall got %b expected 0", busy16); end
    send_frame(1'b1, 8'hC3, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b1, 40);
    checks += 2;
    if (sb16.size() != 0) begin errors++; $display("FAIL n16_missing got %0d pending expected 0", sb16.size()); end
    if (data16 !== 8'hC3) begin errors++; $display("FAIL n16_hold got %h expected c3", data16); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'hAA;
    drive_bit(1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, d[i], 1);
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b expected 1", busy1); end
    rx1 = d[3];
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({data1, done1, perr1, ferr1, busy1} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_outputs got data=%h done=%b perr=%b ferr=%b busy=%b expected all 0",
               data1, done1, perr1, ferr1, busy1);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b0, 1'b1, 15);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 15);
    checks++;
    if (sb1.size() != 0) begin errors++; $display("FAIL midreset_next_missing got %0d pending expected 0", sb1.size()); end
  endtask

  task automatic test_break;
    exp_t e;
    bit   busy_seen;
    e.d  = 8'h00;
    e.pe = 1'b1;
    e.fe = 1'b1;
    e.t  = $time + time'(130);
    sb1.push_back(e);
    busy_seen = 1'b0;
    drive_bit(1'b0, 1'b0, 15);
    for (int i = 0; i < 25; i++) begin
      if (busy1 !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    rx1 = 1'b1;
    repeat (5) begin
      if (busy1 !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    checks += 2;
    if (busy_seen) begin errors++; $display("FAIL break_busy got 1 expected 0 while line held"); end
    if (sb1.size() != 0) begin errors++; $display("FAIL break_missing got %0d pending expected 0", sb1.size()); end
    send_frame(1'b0, 8'h33, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 15);
    checks++;
    if (sb1.size() != 0) begin errors++; $display("FAIL break_recover got %0d pending expected 0", sb1.size()); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_parity_err();
    test_frame_err();
    test_oversample();
    test_reset_mid();
    test_break();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive end of the existing UART transmit path. Deserialises an 11-bit frame: start(0), 8 data bits LSB first, parity, stop(1). Uses the same UART_clk domain and the same parity convention as the transmitter, so the two loop back directly. Optional oversampling allows mid-bit sampling when the line is slower than UART_clk.

Parameters:
ODD_nEVEN, 1, parity select: 1 = odd (expected parity bit = ^data ^ 1), 0 = even (expected = ^data)
SAMPLES_PER_BIT, 1, UART_clk cycles per bit (N >= 1); 1 matches the transmitter (one bit per clock)

Ports:
UART_clk  input  1  receive clock, rising edge
rst  input  1  asynchronous reset, active-high
rx  input  1  serial line, idles high, asynchronous to logic
data_out  output  8  last received data byte, LSB = first data bit
rx_done_tick  output  1  one-cycle pulse; frame complete, data_out and error flags updated
parity_err  output  1  received parity != expected parity, for the last frame
frame_err  output  1  stop bit sampled as 0, for the last frame
rx_busy  output  1  high from start-bit detection until rx_done_tick

Behaviour:
- Synchroniser: rx passes through 2 flops to give rx_sync. Both flops reset to 1. The FSM only uses rx_sync.
- Reset is asynchronous and active-high. On reset: data_out=0, rx_done_tick=0, parity_err=0, frame_err=0, rx_busy=0, FSM=IDLE, counters=0, shift register=0, prev_sample=1.
- Reset mid-frame: the frame is aborted and no rx_done_tick is produced. After reset, the receiver needs a fresh 1->0 edge to start.
- Timing reference: the edge cycle E is the cycle in which rx_sync=0 and prev_sample=1. M = (N-1)/2, using integer division.
- Sample schedule: the start bit is validated at E+M. Data bit k (k=0..7) is sampled at E+M+N*(k+1). Parity is sampled at E+M+9N. Stop is sampled at E+M+10N.
- IDLE:
  - rx_busy=0.
  - On the edge condition: rx_busy=1. If M=0, the start bit is validated in cycle E and the FSM goes to DATA. Otherwise the FSM goes to START with tick_cnt=1.
- START:
  - tick_cnt increments until it equals M.
  - At M: if rx_sync=0, go to DATA with tick_cnt=0. If rx_sync=1 (glitch), return to IDLE, rx_busy=0, and produce no output activity.
- DATA:
  - Each time tick_cnt reaches N-1, sample rx_sync into the shift register (LSB first), wrap tick_cnt to 0, and increment bit_cnt.
  - After the 8th sample, go to PARITY.
- PARITY: sample after N cycles, store the bit, go to STOP.
- STOP: sample after N cycles, go to DONE.
- DONE (one cycle):
  - rx_done_tick=1.
  - data_out = shift register.
  - parity_err = rx_parity ^ (^shift_reg) ^ ODD_nEVEN.
  - frame_err = ~stop_sample.
  - rx_busy falls to 0 in this same cycle. Next state is IDLE.
- Output hold: data_out, parity_err and frame_err hold their values until the next rx_done_tick. They are updated even when an error is flagged.
- Latency: rx_done_tick is asserted in cycle E+M+10N+1. For N=1 this is E+11, which is 13 cycles after the transmitter first drives the start bit.
- Back-to-back frames: a start edge seen in the DONE cycle is ignored. A start bit is detected only after rx_sync has been 1 in IDLE with prev_sample=1.
  - A transmitter with 1 idle bit between frames (N=1) must be received without loss.
  - A break condition (line held at 0) yields exactly one frame with frame_err=1 and data_out=0x00. No further frames are received until the line returns high.
- prev_sample updates every cycle from rx_sync, in all states.
- A line that goes low while in IDLE with prev_sample=0 never starts a frame.

Test Plan:
- Loopback with UART_tx (ODD_nEVEN=1, N=1), sending 0x55, 0x00, 0xFF, 0xA7 with one idle bit between frames -> four rx_done_tick pulses in order, data_out equals each value, parity_err=0 and frame_err=0 each time, each pulse 13 cycles after the corresponding tx start bit.
- Direct drive of frame 0x3C with an inverted parity bit -> rx_done_tick, data_out=0x3C, parity_err=1, frame_err=0.
- Direct drive of frame 0x81 with stop=0, then line high -> data_out=0x81, frame_err=1; the next valid frame 0x12 is received with frame_err=0.
- SAMPLES_PER_BIT=16: a 3-cycle low glitch on an idle line -> no rx_done_tick, rx_busy returns to 0. A full 0xC3 frame at 16 clocks/bit -> data_out=0xC3, rx_done_tick at E+7+160+1.
- Assert rst for 2 cycles during data bit 3 of frame 0xAA -> no rx_done_tick; all outputs are 0 after reset; the next frame 0x5A is received correctly.
- Line held at 0 for 40 cycles (N=1) -> exactly one rx_done_tick with data_out=0x00 and frame_err=1; rx_busy stays 0 until the line returns high and a new edge arrives.
